dds_multiwave_gen: RTL and testbench

//   Parametrised DDS waveform generator that drives the 8-bit DAC feeding the ADC/VGA scope path.

---
 rtl/dds_multiwave_gen.sv | 211 +++++++++++++++++++++
 tb/tb_dds_multiwave_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multiwave_gen.sv
// DDS waveform generator: phase accumulator, quarter-wave sine ROM and a 3-stage sample pipeline.
// Mode, frequency word and attenuation retune on phase wrap so the output never glitches mid-cycle.
module dds_multiwave_gen #(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 8,
  parameter int LUT_AW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [2:0]         ampl_shift,
  input  logic               wave_load,
  output logic [DATA_W-1:0]  dac_da,
  output logic               dac_wra,
  output logic               dac_sleep,
  output logic               load_pend,
  output logic               phase_wrap
);

  localparam int QAW = LUT_AW - 2;
  localparam int QD  = 1 << QAW;
  localparam int MW  = DATA_W - 1;
  localparam logic [DATA_W-1:0] MID    = {1'b1, {MW{1'b0}}};
  localparam logic [DATA_W-1:0] MID_M1 = MID - DATA_W'(1);

  // Half-sample-offset quarter wave from Bhaskara's rational sine approximation, so the
  // mirrored quadrants (~index) land on exactly symmetric phases.
  function automatic logic [QD*MW-1:0] build_sine();
    logic [QD*MW-1:0] t;
    int k, p, num, den;
    t = '0;
    for (int i = 0; i < QD; i++) begin
      k   = 2 * i + 1;
      p   = k * (4 * QD - k);
      num = ((1 << MW) - 1) * 16 * p;
      den = 5 * (4 * QD) * (4 * QD) - 4 * p;
      t[i*MW +: MW] = MW'((2 * num + den) / (2 * den));
    end
    return t;
  endfunction

  localparam logic [QD*MW-1:0] SINE_ROM = build_sine();

  function automatic logic [DATA_W-1:0] scale_lut(input logic [LUT_AW-1:0] x);
    logic [LUT_AW+DATA_W-1:0] w;
    w = {x, {DATA_W{1'b0}}};
    return w[LUT_AW+DATA_W-1 -: DATA_W];
  endfunction

  typedef struct packed {
    logic [2:0]         mode;
    logic [PHASE_W-1:0] freq;
    logic [2:0]         shift;
  } cfg_t;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PEND = 2'd2} state_t;

  state_t             state_q;
  logic [PHASE_W-1:0] acc_q;
  cfg_t               active_q, shadow_q, load_d;
  logic               phase_wrap_q, load_pend_q;
  logic [PHASE_W:0]   sum_d;

  logic               s1_vld_q, s2_vld_q;
  logic [LUT_AW-1:0]  s1_a_q;
  logic [MW-1:0]      s1_mag_q;
  logic [2:0]         s1_mode_q, s1_shift_q, s2_shift_q;
  logic [DATA_W-1:0]  s2_s_q, dac_da_q;
  logic               dac_wra_q, dac_sleep_q;

  logic [LUT_AW-1:0]  a_d, tri_d;
  logic [QAW-1:0]     idx_d;
  logic [MW-1:0]      mag_d;
  logic [DATA_W-1:0]  samp_d, out_d;
  logic signed [DATA_W:0] dev_d, shd_d;
  logic               sleep_d;

  // Accumulator sum, quadrant-folded ROM address and sleep condition.
  always_comb begin
    load_d = {mode, freq_word, ampl_shift};
    sum_d  = {1'b0, acc_q} + {1'b0, active_q.freq};
    a_d    = acc_q[PHASE_W-1 -: LUT_AW];
    if (a_d[LUT_AW-2]) begin
      idx_d = ~a_d[QAW-1:0];
    end else begin
      idx_d = a_d[QAW-1:0];
    end
    mag_d   = SINE_ROM[int'(idx_d)*MW +: MW];
    sleep_d = !en && (state_q == ST_IDLE) && !s1_vld_q && !s2_vld_q;
  end

  // Raw waveform sample (S2 input) and attenuated DAC code (S3 input).
  always_comb begin
    if (s1_a_q[LUT_AW-1]) begin
      tri_d = ~{s1_a_q[LUT_AW-2:0], 1'b0};
    end else begin
      tri_d = {s1_a_q[LUT_AW-2:0], 1'b0};
    end
    case (s1_mode_q)
      3'd1: begin
        if (s1_a_q[LUT_AW-1]) samp_d = MID_M1 - {1'b0, s1_mag_q};
        else                  samp_d = MID + {1'b0, s1_mag_q};
      end
      3'd2:    samp_d = s1_a_q[LUT_AW-1] ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
      3'd3:    samp_d = scale_lut(tri_d);
      3'd4:    samp_d = scale_lut(s1_a_q);
      default: samp_d = MID;
    endcase
    dev_d = $signed({1'b0, s2_s_q}) - $signed({1'b0, MID});
    shd_d = dev_d >>> s2_shift_q;
    out_d = MID + shd_d[DATA_W-1:0];
  end

  // Control FSM: accumulator, active/shadow settings, wrap and pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      phase_wrap_q <= 1'b0;
      load_pend_q  <= 1'b0;
    end else begin
      phase_wrap_q <= 1'b0;
      if (!en) begin
        state_q     <= ST_IDLE;
        acc_q       <= '0;
        load_pend_q <= 1'b0;
        if (wave_load) begin
          shadow_q <= load_d;
          if (state_q == ST_IDLE) active_q <= load_d;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (wave_load) begin
              shadow_q <= load_d;
              active_q <= load_d;
            end
            acc_q   <= '0;
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            acc_q        <= sum_d[PHASE_W-1:0];
            phase_wrap_q <= sum_d[PHASE_W];
            if (wave_load) begin
              shadow_q    <= load_d;
              state_q     <= ST_PEND;
              load_pend_q <= 1'b1;
            end
          end
          ST_PEND: begin
            acc_q        <= sum_d[PHASE_W-1:0];
            phase_wrap_q <= sum_d[PHASE_W];
            if (sum_d[PHASE_W]) begin
              active_q    <= wave_load ? load_d : shadow_q;
              shadow_q    <= wave_load ? load_d : shadow_q;
              state_q     <= ST_RUN;
              load_pend_q <= 1'b0;
            end else if (wave_load) begin
              shadow_q <= load_d;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            load_pend_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sample pipeline; settings travel with each sample so a retune never mixes stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_mag_q    <= '0;
      s1_mode_q   <= 3'd0;
      s1_shift_q  <= 3'd0;
      s2_vld_q    <= 1'b0;
      s2_s_q      <= MID;
      s2_shift_q  <= 3'd0;
      dac_da_q    <= MID;
      dac_wra_q   <= 1'b0;
      dac_sleep_q <= 1'b1;
    end else begin
      s1_vld_q    <= (state_q != ST_IDLE);
      s1_a_q      <= a_d;
      s1_mag_q    <= mag_d;
      s1_mode_q   <= active_q.mode;
      s1_shift_q  <= active_q.shift;
      s2_vld_q    <= s1_vld_q;
      s2_s_q      <= samp_d;
      s2_shift_q  <= s1_shift_q;
      dac_wra_q   <= s2_vld_q;
      dac_da_q    <= s2_vld_q ? out_d : MID;
      dac_sleep_q <= sleep_d;
    end
  end

  assign dac_da     = dac_da_q;
  assign dac_wra    = dac_wra_q;
  assign dac_sleep  = dac_sleep_q;
  assign load_pend  = load_pend_q;
  assign phase_wrap = phase_wrap_q;

endmodule

// File: tb/tb_dds_multiwave_gen.sv
// Bench for dds_multiwave_gen: constant vector table, directed retune/drain/reset sequences and
// randomized traffic, all checked every cycle against an arithmetic phase/waveform model.
module tb_dds_multiwave_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, wave_load;
  logic [2:0]  mode, ampl_shift;
  logic [23:0] freq_word;
  logic [7:0]  dac_da;
  logic        dac_wra, dac_sleep, load_pend, phase_wrap;

  always #5 clk = ~clk;

  dds_multiwave_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .freq_word(freq_word),
    .ampl_shift(ampl_shift), .wave_load(wave_load), .dac_da(dac_da), .dac_wra(dac_wra),
    .dac_sleep(dac_sleep), .load_pend(load_pend), .phase_wrap(phase_wrap)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // reference model state
  bit  m_run, m_pend, m_wrap;
  int  m_phase;
  int  am, af, ash, sm, sf, ssh;
  bit  pv[3];
  int  pval[3];
  bit  ptol[3];

  task automatic check_val(input string name, input int act, input int exp, input int tol);
    total++;
    if (act > exp + tol || act < exp - tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ideal waveform for phase byte a, then floor-divided deviation from midscale
  function automatic int exp_sample(input int a, input int md, input int sh);
    real th, sv;
    int  s, m, dev;
    case (md)
      1: begin
        th = 2.0 * 3.14159265358979 * (a + 0.5) / 256.0;
        sv = $sin(th);
        m  = $rtoi(127.0 * (sv < 0.0 ? -sv : sv) + 0.5);
        s  = (sv >= 0.0) ? 128 + m : 127 - m;
      end
      2: s = (a < 128) ? 255 : 0;
      3: s = (a < 128) ? 2 * a : 255 - 2 * (a - 128);
      4: s = a;
      default: s = 128;
    endcase
    dev = s - 128;
    if (dev >= 0) dev = dev / (1 << sh);
    else          dev = -((-dev + (1 << sh) - 1) / (1 << sh));
    return 128 + dev;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_wrap = 0; m_phase = 0;
    am = 0; af = 0; ash = 0; sm = 0; sf = 0; ssh = 0;
    for (int i = 0; i < 3; i++) begin pv[i] = 0; pval[i] = 128; ptol[i] = 0; end
  endtask

  task automatic model_step();
    longint sum;
    pv[2] = pv[1]; pval[2] = pval[1]; ptol[2] = ptol[1];
    pv[1] = pv[0]; pval[1] = pval[0]; ptol[1] = ptol[0];
    pv[0] = m_run; pval[0] = exp_sample(m_phase >> 16, am, ash); ptol[0] = (am == 1);
    m_wrap = 0;
    if (!en) begin
      if (wave_load) begin
        sm = int'(mode); sf = int'(freq_word); ssh = int'(ampl_shift);
        if (!m_run) begin am = sm; af = sf; ash = ssh; end
      end
      m_run = 0; m_pend = 0; m_phase = 0;
    end else if (!m_run) begin
      if (wave_load) begin
        sm = int'(mode); sf = int'(freq_word); ssh = int'(ampl_shift);
        am = sm; af = sf; ash = ssh;
      end
      m_run = 1; m_phase = 0;
    end else begin
      sum     = longint'(m_phase) + longint'(af);
      m_wrap  = (sum >= 64'd16777216);
      m_phase = int'(sum % 64'd16777216);
      if (wave_load) begin sm = int'(mode); sf = int'(freq_word); ssh = int'(ampl_shift); end
      if (m_pend && m_wrap) begin
        am = sm; af = sf; ash = ssh; m_pend = 0;
      end else if (wave_load) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic compare_all();
    check_val("dac_da", int'(dac_da), pv[2] ? pval[2] : 128, (pv[2] && ptol[2]) ? 1 : 0);
    check_val("dac_wra", int'(dac_wra), int'(pv[2]), 0);
    check_val("dac_sleep", int'(dac_sleep), int'(!m_run && !pv[0] && !pv[1] && !pv[2]), 0);
    check_val("load_pend", int'(load_pend), int'(m_pend), 0);
    check_val("phase_wrap", int'(phase_wrap), int'(m_wrap), 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      if (chk_on) compare_all();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic go_idle();
    en = 1'b0; wave_load = 1'b0;
    repeat (5) step();
  endtask

  task automatic load_start(input int md, input int fw, input int sh);
    mode = 3'(md); freq_word = 24'(fw); ampl_shift = 3'(sh);
    wave_load = 1'b1; en = 1'b1;
    step();
    wave_load = 1'b0;
  endtask

  typedef struct {
    int md; int sh; int fw; int n; int exp; int tol;
  } vec_t;
  vec_t tbl[18];

  initial begin
    int n, cnt;
    tbl[0]  = '{4, 0, 24'h010000, 0,   0,   0};
    tbl[1]  = '{4, 0, 24'h010000, 200, 200, 0};
    tbl[2]  = '{4, 1, 24'h010000, 0,   64,  0};
    tbl[3]  = '{4, 1, 24'h010000, 255, 191, 0};
    tbl[4]  = '{4, 7, 24'h010000, 0,   127, 0};
    tbl[5]  = '{4, 7, 24'h010000, 255, 128, 0};
    tbl[6]  = '{2, 0, 24'h010000, 127, 255, 0};
    tbl[7]  = '{2, 0, 24'h010000, 128, 0,   0};
    tbl[8]  = '{3, 0, 24'h010000, 1,   2,   0};
    tbl[9]  = '{3, 0, 24'h010000, 128, 255, 0};
    tbl[10] = '{3, 0, 24'h010000, 255, 1,   0};
    tbl[11] = '{0, 0, 24'h010000, 10,  128, 0};
    tbl[12] = '{5, 0, 24'h010000, 10,  128, 0};
    tbl[13] = '{2, 2, 24'h010000, 200, 96,  0};
    tbl[14] = '{1, 0, 24'h010000, 64,  255, 1};
    tbl[15] = '{1, 0, 24'h010000, 192, 0,   1};
    tbl[16] = '{4, 0, 24'h030000, 5,   15,  0};
    tbl[17] = '{3, 3, 24'h010000, 100, 137, 0};

    rst_n = 1'b0; en = 1'b0; wave_load = 1'b0; mode = 3'd0; freq_word = 24'd0; ampl_shift = 3'd0;
    repeat (3) step();
    chk_on = 1'b1;
    check_val("rst_dac", int'(dac_da), 128, 0);
    check_val("rst_sleep", int'(dac_sleep), 1, 0);
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      go_idle();
      load_start(tbl[i].md, tbl[i].fw, tbl[i].sh);
      repeat (tbl[i].n + 3) step();
      check_val($sformatf("tbl%0d", i), int'(dac_da), tbl[i].exp, tbl[i].tol);
    end

    // saw at 65536/clk wraps every 256 clks
    go_idle();
    load_start(4, 24'h010000, 0);
    for (int w = 0; w < 2; w++) begin
      n = 0;
      do begin step(); n++; end while (!phase_wrap && n < 600);
      check_val("wrap_period", n, 256, 0);
    end

    // retune saw->square at phase 0x400000, applied only at the next wrap
    go_idle();
    load_start(4, 24'h010000, 0);
    repeat (64) step();
    mode = 3'd2; wave_load = 1'b1;
    step();
    wave_load = 1'b0;
    check_val("pend_set", int'(load_pend), 1, 0);
    repeat (190) step();
    check_val("pend_hold", int'(load_pend), 1, 0);
    step();
    check_val("pend_clear", int'(load_pend), 0, 0);
    check_val("pend_wrap", int'(phase_wrap), 1, 0);
    repeat (2) step();
    check_val("last_saw", int'(dac_da), 255, 0);
    step();
    check_val("first_square", int'(dac_da), 255, 0);
    repeat (128) step();
    check_val("square_low", int'(dac_da), 0, 0);

    // drop en while a load is pending: drain 3 samples, discard the load
    mode = 3'd4; wave_load = 1'b1;
    step();
    wave_load = 1'b0;
    check_val("pend_before_drop", int'(load_pend), 1, 0);
    en = 1'b0;
    cnt = 0;
    repeat (6) begin step(); if (dac_wra) cnt++; end
    check_val("drain_pulses", cnt, 3, 0);
    check_val("drain_dac", int'(dac_da), 128, 0);
    check_val("drain_sleep", int'(dac_sleep), 1, 0);
    check_val("drain_pend", int'(load_pend), 0, 0);
    en = 1'b1;
    repeat (4) step();
    check_val("discard_load", int'(dac_da), 255, 0);

    // asynchronous reset in the middle of RUN
    repeat (40) step();
    rst_n = 1'b0;
    #1;
    check_val("arst_dac", int'(dac_da), 128, 0);
    check_val("arst_sleep", int'(dac_sleep), 1, 0);
    check_val("arst_wra", int'(dac_wra), 0, 0);
    check_val("arst_acc", int'(dut.acc_q), 0, 0);
    step();
    rst_n = 1'b1;
    step();

    // randomized traffic against the model
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      int r, fsel;
      step();
      wave_load = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        wave_load  = 1'b1;
        mode       = 3'($urandom_range(0, 7));
        ampl_shift = 3'($urandom_range(0, 7));
        fsel       = $urandom_range(0, 3);
        case (fsel)
          0:       freq_word = 24'($urandom);
          1:       freq_word = 24'($urandom_range(0, 24'h040000));
          2:       freq_word = 24'd0;
          default: freq_word = 24'h800000;
        endcase
      end
      if (r >= 4 && r < 6) en = 1'b0;
      else if (!en && $urandom_range(0, 9) < 3) en = 1'b1;
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
